ps2_host_tx: RTL and testbench

- Host-to-device transmitter for the PS/2 mouse port. It sends one command byte to the mouse, for example 0xF4 (enable data reporting) or 0xFF (reset).
- Sits beside the existing PS/2 mouse receiver on the same ps2c/ps2d pins and drives them through open-drain enables.
- Implements the full PS/2 host-to-device frame: clock inhibit, request-to-send, 8 data bits, odd parity, stop bit, device ACK, with timeout and error reporting.

---
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity and stop bit, then the device ACK, with an overall frame timeout.
module ps2_host_tx #(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clock,
    input  logic       resetApp,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic [1:0] tx_error
);

    localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    localparam logic [IW-1:0] INH_PRE   = IW'(INHIBIT_CYCLES - 2);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] SHIFT     = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    if (CLOCK_FREQ < 1 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 1) begin : gBadParams
        $error("ps2_host_tx: invalid parameter set");
    end

    logic [1:0]    cSync, dSync;
    logic          syncC, syncD;
    logic          filtC, filtCPrev;
    logic [FW-1:0] filtCnt;
    logic          fall;

    logic [2:0]    state;
    logic [IW-1:0] inhCnt;
    logic [TW-1:0] toCnt;
    logic [3:0]    bitCnt;
    logic [8:0]    frame;
    logic          ps2cOe, ps2dOe, busy, doneTick;
    logic [1:0]    txErr;
    logic          timed;

    // Synchronisers idle high so reset release never looks like a clock fall.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            cSync <= 2'b11;
            dSync <= 2'b11;
        end else begin
            cSync <= {cSync[0], ps2c_in};
            dSync <= {dSync[0], ps2d_in};
        end
    end

    assign syncC = cSync[1];
    assign syncD = dSync[1];

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            filtC     <= 1'b1;
            filtCPrev <= 1'b1;
            filtCnt   <= '0;
        end else begin
            filtCPrev <= filtC;
            if (syncC == filtC) begin
                filtCnt <= '0;
            end else if (filtCnt == FILT_LAST) begin
                filtC   <= syncC;
                filtCnt <= '0;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
        end
    end

    assign fall  = filtCPrev & ~filtC;
    assign timed = (state == START) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state    <= IDLE;
            inhCnt   <= '0;
            toCnt    <= '0;
            bitCnt   <= '0;
            frame    <= '0;
            ps2cOe   <= 1'b0;
            ps2dOe   <= 1'b0;
            busy     <= 1'b0;
            doneTick <= 1'b0;
            txErr    <= 2'b00;
        end else begin
            doneTick <= 1'b0;
            case (state)
                IDLE: begin
                    ps2cOe <= 1'b0;
                    ps2dOe <= 1'b0;
                    // busy spans the done-tick cycle, so a start coinciding with it is dropped
                    if (doneTick) busy <= 1'b0;
                    if (tx_start && !busy) begin
                        frame  <= {~^tx_data, tx_data};
                        txErr  <= 2'b00;
                        busy   <= 1'b1;
                        ps2cOe <= 1'b1;
                        inhCnt <= '0;
                        state  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    inhCnt <= inhCnt + 1'b1;
                    // data goes low one cycle before clock is released
                    if (inhCnt == INH_PRE) ps2dOe <= 1'b1;
                    if (inhCnt == INH_LAST) begin
                        ps2dOe <= 1'b1;
                        ps2cOe <= 1'b0;
                        toCnt  <= '0;
                        state  <= START;
                    end
                end
                START: begin
                    ps2dOe <= 1'b1;
                    bitCnt <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (fall) begin
                        if (bitCnt == 4'd9) begin
                            ps2dOe <= 1'b0;
                            state  <= ACK;
                        end else begin
                            ps2dOe <= ~frame[bitCnt];
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (fall) begin
                        txErr <= syncD ? 2'b01 : 2'b00;
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (filtC && syncD) begin
                        doneTick <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Timeout wins over whatever the frame states decided this cycle.
            if (timed) begin
                toCnt <= toCnt + 1'b1;
                if (toCnt == TO_LAST) begin
                    ps2cOe   <= 1'b0;
                    ps2dOe   <= 1'b0;
                    txErr    <= 2'b10;
                    doneTick <= 1'b1;
                    state    <= IDLE;
                end
            end
        end
    end

    assign ps2c_oe      = ps2cOe;
    assign ps2d_oe      = ps2dOe;
    assign tx_busy      = busy;
    assign tx_done_tick = doneTick;
    assign tx_error     = txErr;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard checks frame bits at device sample points and tx_error at each done tick.
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int TO   = 3000;
    localparam int FL   = 8;
    localparam int HALF = 30;

    logic       clock = 1'b0;
    logic       resetApp;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2c_oe, ps2d_oe, tx_busy, tx_done_tick;
    logic [1:0] tx_error;
    logic       devClkLow = 1'b0;
    logic       devDataLow = 1'b0;
    logic       ps2cBus, ps2dBus;

    int vectors = 0;
    int miscompares = 0;
    int doneCnt = 0;
    logic [1:0] errQ[$];
    logic       bitQ[$];

    assign ps2cBus = ~(ps2c_oe | devClkLow);
    assign ps2dBus = ~(ps2d_oe | devDataLow);

    ps2_host_tx #(
        .CLOCK_FREQ(50000000), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)
    ) dut (
        .clock(clock), .resetApp(resetApp), .tx_data(tx_data), .tx_start(tx_start),
        .ps2c_in(ps2cBus), .ps2d_in(ps2dBus), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx_error(tx_error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Done-tick monitor: every tick must match the next queued expected error code.
    always @(negedge clock) begin
        if (tx_done_tick) begin
            logic [1:0] expErr;
            doneCnt++;
            expErr = (errQ.size() > 0) ? errQ.pop_front() : 2'bxx;
            chk("tx_error at done tick", {30'd0, tx_error}, {30'd0, expErr});
        end
    end

    task automatic push_frame(input logic [9:0] f, input int n);
        for (int i = 0; i < n; i++) bitQ.push_back(f[i]);
    endtask

    task automatic start(input logic [7:0] d);
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    task automatic wait_request();
        int n = 0;
        while (ps2c_oe && n < INH + 50) begin
            @(negedge clock);
            n++;
        end
        chk("ps2c_oe released after inhibit", {31'd0, ps2c_oe}, 32'd0);
        chk("start bit driven", {31'd0, ps2d_oe}, 32'd1);
    endtask

    // Device clocks nFalls periods, sampling data just before each rise.
    task automatic device_clock(input int nFalls, input bit ack);
        repeat (20) @(negedge clock);
        for (int k = 1; k <= nFalls; k++) begin
            devClkLow = 1'b1;
            repeat (HALF) @(negedge clock);
            if (k <= 10) chk($sformatf("frame bit at fall %0d", k), {31'd0, ps2dBus},
                             {31'd0, (bitQ.size() > 0) ? bitQ.pop_front() : 1'bx});
            devClkLow = 1'b0;
            if (k == 10 && ack) begin
                repeat (5) @(negedge clock);
                devDataLow = 1'b1;
                repeat (HALF - 5) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            if (k == 11) devDataLow = 1'b0;
        end
    endtask

    task automatic wait_done(input int prevDone, input logic [1:0] expErr);
        int n = 0;
        while (tx_busy && n < 4000) begin
            @(negedge clock);
            n++;
        end
        chk("tx_busy low after transaction", {31'd0, tx_busy}, 32'd0);
        chk("one done tick per transaction", doneCnt, prevDone + 1);
        chk("tx_error held", {30'd0, tx_error}, {30'd0, expErr});
        chk("lines released", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
    endtask

    task automatic run_tx(input logic [7:0] d, input logic [9:0] f, input logic [1:0] e, input bit ack);
        int prev = doneCnt;
        errQ.push_back(e);
        push_frame(f, 10);
        start(d);
        wait_request();
        device_clock(11, ack);
        wait_done(prev, e);
    endtask

    initial begin
        int cnt, dAt, n, prev;
        resetApp = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clock);
        chk("reset ps2c_oe", {31'd0, ps2c_oe}, 32'd0);
        chk("reset ps2d_oe", {31'd0, ps2d_oe}, 32'd0);
        chk("reset tx_busy", {31'd0, tx_busy}, 32'd0);
        chk("reset tx_done_tick", {31'd0, tx_done_tick}, 32'd0);
        chk("reset tx_error", {30'd0, tx_error}, 32'd0);
        resetApp = 1'b0;
        repeat (20) @(negedge clock);

        // 0xF4 with inhibit timing measured: bits 0,0,1,0,1,1,1,1, parity 0, stop 1
        prev = doneCnt;
        errQ.push_back(2'b00);
        push_frame(10'b1_0_11110100, 10);
        start(8'hF4);
        chk("tx_busy after start", {31'd0, tx_busy}, 32'd1);
        cnt = 0; dAt = 0; n = 0;
        while (ps2c_oe && n < INH + 100) begin
            cnt++;
            if (ps2d_oe && dAt == 0) dAt = cnt;
            @(negedge clock);
            n++;
        end
        chk("inhibit length", cnt, INH);
        chk("data low in last inhibit cycle", dAt, INH);
        chk("start bit after inhibit", {31'd0, ps2d_oe}, 32'd1);
        device_clock(11, 1'b1);
        wait_done(prev, 2'b00);

        // 0xFF: all ones, parity 1
        run_tx(8'hFF, 10'b1_1_11111111, 2'b00, 1'b1);

        // 0xE8 with no ACK from the device: parity 1
        run_tx(8'hE8, 10'b1_1_11101000, 2'b01, 1'b0);

        // 0xF4 with a second start of 0x00 mid-frame, which must be ignored
        prev = doneCnt;
        errQ.push_back(2'b00);
        push_frame(10'b1_0_11110100, 10);
        start(8'hF4);
        wait_request();
        fork
            device_clock(11, 1'b1);
            begin
                repeat (150) @(negedge clock);
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
                chk("busy through ignored start", {31'd0, tx_busy}, 32'd1);
            end
        join
        wait_done(prev, 2'b00);

        // Device never clocks: timeout exactly TO cycles after START
        errQ.push_back(2'b10);
        start(8'hF4);
        wait_request();
        n = 0;
        while (ps2d_oe && n < TO + 100) begin
            @(negedge clock);
            n++;
        end
        chk("timeout latency", n, TO);
        chk("tx_error on timeout", {30'd0, tx_error}, 32'd2);
        chk("done tick on timeout", {31'd0, tx_done_tick}, 32'd1);
        chk("busy during done tick", {31'd0, tx_busy}, 32'd1);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        chk("start during done tick ignored", {30'd0, ps2c_oe, tx_busy}, 32'd0);
        @(negedge clock);
        chk("still idle after dropped start", {31'd0, ps2c_oe}, 32'd0);
        chk("timeout error held", {30'd0, tx_error}, 32'd2);
        repeat (20) @(negedge clock);

        // Reset at fall 5 while bit 3 (0) is being driven
        prev = doneCnt;
        push_frame(10'b1_0_11110100, 4);
        start(8'hF4);
        wait_request();
        device_clock(4, 1'b0);
        devClkLow = 1'b1;
        repeat (2) @(negedge clock);
        chk("bit 3 driven before reset", {31'd0, ps2d_oe}, 32'd1);
        #2 resetApp = 1'b1;
        #1;
        chk("async reset releases lines", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
        chk("async reset clears busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clock);
        devClkLow = 1'b0;
        repeat (3) @(negedge clock);
        resetApp = 1'b0;
        repeat (50) @(negedge clock);
        chk("no done tick on reset", doneCnt, prev);
        chk("idle after reset", {30'd0, tx_busy, ps2c_oe}, 32'd0);
        chk("frame bits all consumed", bitQ.size(), 0);
        chk("expected done ticks all seen", errQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
